// File: rtl/cflog_pkg.sv
// Shared types and defaults for the CFLog writer: entry layout, FSM encoding, address helper.
package cflog_pkg;

  typedef struct packed {
    logic [15:0] src;
    logic [15:0] dest;
  } cflog_entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_SRC = 2'd1,
    WR_DST = 2'd2,
    FULL   = 2'd3
  } cflog_state_t;

  localparam logic [15:0] LOG_BASE_DEFAULT   = 16'hE000;
  localparam int          LOG_WORDS_DEFAULT  = 256;
  localparam int          FIFO_DEPTH_DEFAULT = 2;

  // Byte address of CFLog word `ptr` (16-bit words, so shift left by one).
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [15:0] ptr);
    return base + {ptr[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/cflog_fifo.sv
// Small synchronous FIFO of CFLog entries. With CFLOG_DEDUP_EN defined it also exposes the youngest entry (tail).
module cflog_fifo
  import cflog_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  cflog_entry_t din,
  input  logic         pop,
  output cflog_entry_t dout,
  output logic         full,
  output logic         empty
`ifdef CFLOG_DEDUP_EN
  ,
  output cflog_entry_t tail
`endif
);

  localparam int AW = $clog2(DEPTH);

  cflog_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];
`ifdef CFLOG_DEDUP_EN
  assign tail    = mem[wr_ptr - AW'(1)];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cflog_writer.sv
// Commits {src,dest} control-flow events to the CFLog RAM as two words, with pointer, full and overflow tracking.
// Optional build macro CFLOG_DEDUP_EN drops events repeating the last committed or youngest queued entry.
module cflog_writer
  import cflog_pkg::*;
#(
  parameter logic [15:0] LOG_BASE   = LOG_BASE_DEFAULT,
  parameter int          LOG_WORDS  = LOG_WORDS_DEFAULT,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        log_en,
  input  logic [15:0] cflow_src,
  input  logic [15:0] cflow_dest,
  input  logic        flush,
  output logic        mem_wen,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_din,
  output logic [15:0] log_ptr,
  output logic        log_full,
  output logic        log_ovf
);

  localparam logic [15:0] LOG_WORDS_W = 16'(LOG_WORDS);

  cflog_state_t state, state_next;
  cflog_entry_t ev, cur, fifo_dout;
  logic         fifo_full, fifo_empty, fifo_push, pop, dup, ovf_set;
  logic         flush_pend, flush_pend_next, flush_eff, rewind;
  logic [15:0]  ptr_next, addr_next, din_next;
  logic         wen_next;

  assign ev        = {cflow_src, cflow_dest};
  assign fifo_push = log_en & ~dup & ~fifo_full;
  assign ovf_set   = log_en & ~dup & fifo_full;
  assign flush_eff = flush | flush_pend;

`ifdef CFLOG_DEDUP_EN
  cflog_entry_t fifo_tail, last_entry;
  logic         last_valid;

  assign dup = log_en & ((last_valid & (ev == last_entry)) | (~fifo_empty & (ev == fifo_tail)));

  // Remember the most recently committed entry; a rewind forgets it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_entry <= '0;
    end else if (rewind) begin
      last_valid <= 1'b0;
    end else if (state == WR_DST) begin
      last_valid <= 1'b1;
      last_entry <= cur;
    end
  end
`else
  assign dup = 1'b0;
`endif

  cflog_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (ev),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
`ifdef CFLOG_DEDUP_EN
    ,
    .tail  (fifo_tail)
`endif
  );

  // The head is taken out of the FIFO when the drain starts, so a full FIFO plus the in-flight entry can be held.
  always_comb begin
    state_next      = state;
    ptr_next        = log_ptr;
    flush_pend_next = flush_pend;
    pop             = 1'b0;
    rewind          = 1'b0;
    wen_next        = 1'b0;
    addr_next       = 16'h0000;
    din_next        = 16'h0000;
    case (state)
      IDLE: begin
        if (flush_eff) begin
          rewind          = 1'b1;
          ptr_next        = 16'h0000;
          flush_pend_next = 1'b0;
        end else if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = WR_SRC;
          wen_next   = 1'b1;
          addr_next  = word_addr(LOG_BASE, log_ptr);
          din_next   = fifo_dout.src;
        end else begin
          state_next = IDLE;
        end
      end
      WR_SRC: begin
        if (flush) flush_pend_next = 1'b1;
        else       flush_pend_next = flush_pend;
        state_next = WR_DST;
        wen_next   = 1'b1;
        addr_next  = mem_addr + 16'd2;
        din_next   = cur.dest;
      end
      WR_DST: begin
        if (flush) flush_pend_next = 1'b1;
        else       flush_pend_next = flush_pend;
        ptr_next = log_ptr + 16'd2;
        if (ptr_next == LOG_WORDS_W) state_next = FULL;
        else                         state_next = IDLE;
      end
      FULL: begin
        if (flush_eff) begin
          rewind          = 1'b1;
          ptr_next        = 16'h0000;
          flush_pend_next = 1'b0;
          state_next      = IDLE;
        end else begin
          state_next = FULL;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, pointer and registered RAM/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      log_ptr    <= 16'h0000;
      flush_pend <= 1'b0;
      cur        <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= 16'h0000;
      mem_din    <= 16'h0000;
      log_full   <= 1'b0;
      log_ovf    <= 1'b0;
    end else begin
      state      <= state_next;
      log_ptr    <= ptr_next;
      flush_pend <= flush_pend_next;
      mem_wen    <= wen_next;
      mem_addr   <= addr_next;
      mem_din    <= din_next;
      log_full   <= (state_next == FULL);
      if (pop)     cur     <= fifo_dout;
      if (ovf_set) log_ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cflog_writer.sv
// Scoreboard bench for cflog_writer (LOG_WORDS=8): expected RAM writes are queued, a negedge monitor checks them.
module tb_cflog_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        log_en = 1'b0;
  logic [15:0] cflow_src = 16'h0000;
  logic [15:0] cflow_dest = 16'h0000;
  logic        flush = 1'b0;
  logic        mem_wen;
  logic [15:0] mem_addr;
  logic [15:0] mem_din;
  logic [15:0] log_ptr;
  logic        log_full;
  logic        log_ovf;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  cflog_writer #(.LOG_BASE(16'hE000), .LOG_WORDS(8), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .log_en(log_en), .cflow_src(cflow_src), .cflow_dest(cflow_dest),
    .flush(flush), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_din(mem_din),
    .log_ptr(log_ptr), .log_full(log_full), .log_ovf(log_ovf)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
  endtask

  task automatic ev(input logic [15:0] s, input logic [15:0] d);
    log_en = 1'b1; cflow_src = s; cflow_dest = d;
    cyc(1);
    log_en = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc(1);
    flush = 1'b0;
  endtask

  task automatic expect_entry(input logic [15:0] addr, input logic [15:0] s, input logic [15:0] d);
    exp_q.push_back({addr, s});
    exp_q.push_back({addr + 16'd2, d});
  endtask

  // Monitor: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst && mem_wen) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_din);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_din} === e) n_pass++;
        else $display("FAIL mem_write: got addr %h data %h expected addr %h data %h",
                      mem_addr, mem_din, e[31:16], e[15:0]);
      end
    end
  end

  initial begin
    logic [15:0] a;
    // 1: reset state and a single event
    do_reset();
    chk("rst_ptr", log_ptr, 16'd0);
    chk("rst_full", {15'd0, log_full}, 16'd0);
    chk("rst_ovf", {15'd0, log_ovf}, 16'd0);
    chk("rst_wen", {15'd0, mem_wen}, 16'd0);
    expect_entry(16'hE000, 16'h1234, 16'h5678);
    ev(16'h1234, 16'h5678);
    cyc(5);
    chk("t1_ptr", log_ptr, 16'd2);
    chk("t1_ovf", {15'd0, log_ovf}, 16'd0);

    // 2: three back-to-back events fit in FIFO plus in-flight entry
    do_reset();
    expect_entry(16'hE000, 16'h1111, 16'h2222);
    expect_entry(16'hE004, 16'h3333, 16'h4444);
    expect_entry(16'hE008, 16'h5555, 16'h6666);
    ev(16'h1111, 16'h2222);
    ev(16'h3333, 16'h4444);
    ev(16'h5555, 16'h6666);
    cyc(12);
    chk("t2_ovf", {15'd0, log_ovf}, 16'd0);
    chk("t2_ptr", log_ptr, 16'd6);
    chk("t2_full", {15'd0, log_full}, 16'd0);

    // 3: fill to capacity, 5th event waits in FIFO until flush
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 16'hE000 + 16'(4 * i);
      expect_entry(a, 16'hA000 + 16'(i), 16'hB000 + 16'(i));
      ev(16'hA000 + 16'(i), 16'hB000 + 16'(i));
      cyc(4);
    end
    chk("t3_ptr_full", log_ptr, 16'd8);
    chk("t3_full", {15'd0, log_full}, 16'd1);
    ev(16'hA004, 16'hB004);
    cyc(5);
    chk("t3_held_ptr", log_ptr, 16'd8);
    chk("t3_held_full", {15'd0, log_full}, 16'd1);
    expect_entry(16'hE000, 16'hA004, 16'hB004);
    do_flush();
    chk("t3_rewind_ptr", log_ptr, 16'd0);
    chk("t3_rewind_full", {15'd0, log_full}, 16'd0);
    cyc(6);
    chk("t3_after_ptr", log_ptr, 16'd2);

    // 4: flush during WR_SRC completes current entry, next one lands at base
    do_reset();
    expect_entry(16'hE000, 16'h0101, 16'h0202);
    ev(16'h0101, 16'h0202);
    cyc(4);
    expect_entry(16'hE004, 16'h0303, 16'h0404);
    ev(16'h0303, 16'h0404);
    cyc(1);
    chk("t4_in_wr_src", {15'd0, mem_wen}, 16'd1);
    do_flush();
    cyc(4);
    chk("t4_rewound", log_ptr, 16'd0);
    expect_entry(16'hE000, 16'h0505, 16'h0606);
    ev(16'h0505, 16'h0606);
    cyc(5);
    chk("t4_ptr", log_ptr, 16'd2);

    // 5: overflow while FULL is sticky across flush, cleared by reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 16'hE000 + 16'(4 * i);
      expect_entry(a, 16'hC000 + 16'(i), 16'hD000 + 16'(i));
      ev(16'hC000 + 16'(i), 16'hD000 + 16'(i));
      cyc(4);
    end
    ev(16'h7001, 16'h8001);
    ev(16'h7002, 16'h8002);
    cyc(1);
    chk("t5_no_ovf_yet", {15'd0, log_ovf}, 16'd0);
    ev(16'h7003, 16'h8003);
    cyc(1);
    chk("t5_ovf", {15'd0, log_ovf}, 16'd1);
    expect_entry(16'hE000, 16'h7001, 16'h8001);
    expect_entry(16'hE004, 16'h7002, 16'h8002);
    do_flush();
    cyc(10);
    chk("t5_ovf_after_flush", {15'd0, log_ovf}, 16'd1);
    chk("t5_ptr", log_ptr, 16'd4);
    do_reset();
    chk("t5_ovf_reset", {15'd0, log_ovf}, 16'd0);

    // 6: repeated event, deduplicated only when the option is built in
    do_reset();
    expect_entry(16'hE000, 16'hAAAA, 16'hBBBB);
`ifdef CFLOG_DEDUP_EN
    expect_entry(16'hE004, 16'hCCCC, 16'hDDDD);
`else
    expect_entry(16'hE004, 16'hAAAA, 16'hBBBB);
    expect_entry(16'hE008, 16'hCCCC, 16'hDDDD);
`endif
    ev(16'hAAAA, 16'hBBBB);
    cyc(4);
    ev(16'hAAAA, 16'hBBBB);
    cyc(4);
    ev(16'hCCCC, 16'hDDDD);
    cyc(5);
`ifdef CFLOG_DEDUP_EN
    chk("t6_ptr", log_ptr, 16'd4);
`else
    chk("t6_ptr", log_ptr, 16'd6);
`endif
    chk("t6_ovf", {15'd0, log_ovf}, 16'd0);

    cyc(2);
    chk("pending_writes", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
